toe_conn_ctrl: RTL and testbench

Parametrised Avalon-MM control block for the TOE connection table. Software stages a connection tuple in CSRs and issues lookup, insert or delete requests. Requests are queued in a command FIFO and sequenced to the RAM searcher one at a time. Each completion lands in a result FIFO with error, ID and timeout status, and can raise an interrupt. It replaces the single-shot request/done handshake with queued, interrupt-capable operation and 48-bit MAC support.

---
 rtl/toe_conn_ctrl_if.sv | 37 +++
 rtl/toe_conn_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_toe_conn_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/toe_conn_ctrl_if.sv
// Bus bundle for toe_conn_ctrl: Avalon-MM CSR port plus the request/completion port to the RAM searcher.
// Searcher handshake: rs_rq != 0 with the tuple outputs is a request held stable until one rs_done pulse completes it.
interface toe_conn_ctrl_if #(
    parameter int ID_W  = 8,
    parameter int MAC_W = 48
);
    logic [31:0]      writedata;
    logic             write;
    logic [31:0]      readdata;
    logic             read;
    logic             chipselect;
    logic [3:0]       address;
    logic             irq;
    logic [1:0]       rs_rq;
    logic [31:0]      rs_ip_src;
    logic [31:0]      rs_ip_dst;
    logic [MAC_W-1:0] rs_mac_src;
    logic [MAC_W-1:0] rs_mac_dst;
    logic [15:0]      rs_port_src;
    logic [15:0]      rs_port_dst;
    logic [ID_W-1:0]  rs_id_out;
    logic [ID_W-1:0]  rs_id_in;
    logic [7:0]       rs_error;
    logic             rs_done;

    modport slave (
        input  writedata, write, read, chipselect, address, rs_id_in, rs_error, rs_done,
        output readdata, irq, rs_rq, rs_ip_src, rs_ip_dst, rs_mac_src, rs_mac_dst,
               rs_port_src, rs_port_dst, rs_id_out
    );

    modport master (
        output writedata, write, read, chipselect, address, rs_id_in, rs_error, rs_done,
        input  readdata, irq, rs_rq, rs_ip_src, rs_ip_dst, rs_mac_src, rs_mac_dst,
               rs_port_src, rs_port_dst, rs_id_out
    );
endinterface

// File: rtl/toe_conn_ctrl.sv
// Queued CSR front end for the TOE connection table: command FIFO -> searcher sequencer -> result FIFO + irq.
// Optional WAIT timeout is enabled by defining TOE_CONN_CTRL_TIMEOUT_EN.
module toe_conn_ctrl #(
    parameter int DEPTH   = 4,
    parameter int ID_W    = 8,
    parameter int MAC_W   = 48,
    parameter int TIMEOUT = 1023
) (
    input  logic           clk,
    input  logic           rst,
    toe_conn_ctrl_if.slave bus,
    output logic [1:0]     state_dbg
);
    localparam int AW = $clog2(DEPTH);
    localparam int HW = MAC_W - 32;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    typedef struct packed {
        logic [1:0]       code;
        logic [31:0]      ip_src;
        logic [31:0]      ip_dst;
        logic [MAC_W-1:0] mac_src;
        logic [MAC_W-1:0] mac_dst;
        logic [15:0]      port_src;
        logic [15:0]      port_dst;
        logic [ID_W-1:0]  id;
    } cmd_t;

    typedef struct packed {
        logic [7:0]      error;
        logic            timeout;
        logic [1:0]      code;
        logic [ID_W-1:0] id;
    } res_t;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

    state_t           state, state_nx;
    cmd_t             cmd_mem [DEPTH];
    res_t             res_mem [DEPTH];
    logic [AW-1:0]    cmd_wp, cmd_rp, res_wp, res_rp;
    logic [AW:0]      cmd_cnt, res_cnt;
    logic [31:0]      ip_src, ip_dst;
    logic [MAC_W-1:0] mac_src, mac_dst;
    logic [15:0]      port_src, port_dst;
    logic [ID_W-1:0]  id_out;
    logic             irq_en, ovf;
    logic             wr, rd, in_wait, push_req;
    logic             cmd_full, cmd_empty, res_full, res_empty;
    logic             cmd_push, cmd_drop, cmd_pop, res_push, res_pop, tmo;
    cmd_t             head, cmd_in;
    res_t             res_head, res_in;
    logic [31:0]      rd_val;

    assign wr        = bus.write & bus.chipselect;
    assign rd        = bus.read & bus.chipselect;
    assign in_wait   = (state == S_WAIT);
    assign cmd_full  = (cmd_cnt == FULL_CNT);
    assign cmd_empty = (cmd_cnt == '0);
    assign res_full  = (res_cnt == FULL_CNT);
    assign res_empty = (res_cnt == '0);
    assign head      = cmd_mem[cmd_rp];
    assign res_head  = res_mem[res_rp];
    assign state_dbg = state;

    // A full command FIFO still accepts a push when the sequencer frees the head slot this cycle.
    assign push_req = wr && (bus.address == 4'h0) && (bus.writedata[1:0] != 2'b00);
    assign cmd_push = push_req && (!cmd_full || cmd_pop);
    assign cmd_drop = push_req && cmd_full && !cmd_pop;
    assign res_pop  = wr && (bus.address == 4'h1) && bus.writedata[0] && !res_empty;

    assign cmd_in = '{code: bus.writedata[1:0], ip_src: ip_src, ip_dst: ip_dst,
                      mac_src: mac_src, mac_dst: mac_dst, port_src: port_src,
                      port_dst: port_dst, id: id_out};

`ifdef TOE_CONN_CTRL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           wait_cnt <= '0;
        else if (!in_wait) wait_cnt <= '0;
        else               wait_cnt <= wait_cnt + 1'b1;
    end

    // Fires on the TIMEOUT-th WAIT cycle; the counter would reach TIMEOUT on that edge.
    assign tmo = in_wait && (wait_cnt == CW'(TIMEOUT - 1));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        cmd_pop  = 1'b0;
        res_push = 1'b0;
        res_in   = '0;
        case (state)
            S_IDLE: if (!cmd_empty && !res_full) state_nx = S_WAIT;
            S_WAIT: begin
                if (bus.rs_done) begin
                    state_nx       = S_DONE;
                    cmd_pop        = 1'b1;
                    res_push       = 1'b1;
                    res_in.error   = bus.rs_error;
                    res_in.code    = head.code;
                    res_in.id      = bus.rs_id_in;
                end else if (tmo) begin
                    state_nx       = S_DONE;
                    cmd_pop        = 1'b1;
                    res_push       = 1'b1;
                    res_in.error   = 8'hFF;
                    res_in.timeout = 1'b1;
                    res_in.code    = head.code;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign bus.rs_rq       = in_wait ? head.code     : 2'b00;
    assign bus.rs_ip_src   = in_wait ? head.ip_src   : '0;
    assign bus.rs_ip_dst   = in_wait ? head.ip_dst   : '0;
    assign bus.rs_mac_src  = in_wait ? head.mac_src  : '0;
    assign bus.rs_mac_dst  = in_wait ? head.mac_dst  : '0;
    assign bus.rs_port_src = in_wait ? head.port_src : '0;
    assign bus.rs_port_dst = in_wait ? head.port_dst : '0;
    assign bus.rs_id_out   = in_wait ? head.id       : '0;

    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem[cmd_wp] <= cmd_in;
        if (res_push) res_mem[res_wp] <= res_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_wp  <= '0;
            cmd_rp  <= '0;
            cmd_cnt <= '0;
            res_wp  <= '0;
            res_rp  <= '0;
            res_cnt <= '0;
        end else begin
            if (cmd_push) cmd_wp <= cmd_wp + 1'b1;
            if (cmd_pop)  cmd_rp <= cmd_rp + 1'b1;
            if (res_push) res_wp <= res_wp + 1'b1;
            if (res_pop)  res_rp <= res_rp + 1'b1;
            cmd_cnt <= cmd_cnt + {{AW{1'b0}}, cmd_push} - {{AW{1'b0}}, cmd_pop};
            res_cnt <= res_cnt + {{AW{1'b0}}, res_push} - {{AW{1'b0}}, res_pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ip_src   <= '0;
            ip_dst   <= '0;
            mac_src  <= '0;
            mac_dst  <= '0;
            port_src <= '0;
            port_dst <= '0;
            id_out   <= '0;
            irq_en   <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (wr) begin
                case (bus.address)
                    4'h3: ip_src               <= bus.writedata;
                    4'h4: ip_dst               <= bus.writedata;
                    4'h5: mac_src[31:0]        <= bus.writedata;
                    4'h6: mac_src[MAC_W-1:32]  <= bus.writedata[HW-1:0];
                    4'h7: mac_dst[31:0]        <= bus.writedata;
                    4'h8: mac_dst[MAC_W-1:32]  <= bus.writedata[HW-1:0];
                    4'h9: {port_dst, port_src} <= bus.writedata;
                    4'hA: id_out               <= bus.writedata[ID_W-1:0];
                    4'hB: irq_en               <= bus.writedata[0];
                    default: ;
                endcase
            end
            if (cmd_drop)
                ovf <= 1'b1;
            else if (wr && (bus.address == 4'h1) && bus.writedata[2])
                ovf <= 1'b0;
        end
    end

    always_comb begin
        rd_val = '0;
        case (bus.address)
            4'h0: rd_val = {23'd0, (state != S_IDLE), 6'd0, bus.rs_rq};
            4'h1: rd_val = {8'd0, 8'(res_cnt), 8'(cmd_cnt), 5'd0, ovf, cmd_full, !res_empty};
            4'h2: if (!res_empty) begin
                rd_val[7:0]         = res_head.error;
                rd_val[8]           = res_head.timeout;
                rd_val[10:9]        = res_head.code;
                rd_val[16 +: ID_W]  = res_head.id;
            end
            4'h3: rd_val = ip_src;
            4'h4: rd_val = ip_dst;
            4'h5: rd_val = mac_src[31:0];
            4'h6: rd_val[HW-1:0] = mac_src[MAC_W-1:32];
            4'h7: rd_val = mac_dst[31:0];
            4'h8: rd_val[HW-1:0] = mac_dst[MAC_W-1:32];
            4'h9: rd_val = {port_dst, port_src};
            4'hA: rd_val[ID_W-1:0] = id_out;
            4'hB: rd_val[0] = irq_en;
            default: rd_val = '0;
        endcase
    end

    // readdata samples pre-write state, so a same-cycle write does not show until the next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.readdata <= '0;
            bus.irq      <= 1'b0;
        end else begin
            if (rd) bus.readdata <= rd_val;
            bus.irq <= irq_en & !res_empty;
        end
    end
endmodule

// File: tb/tb_toe_conn_ctrl.sv
// Self-checking bench for toe_conn_ctrl: transaction-level model of the CMD/RES queues and staging registers.
`timescale 1ns/1ps
module tb_toe_conn_ctrl;
    localparam int DEPTH   = 4;
    localparam int ID_W    = 8;
    localparam int MAC_W   = 48;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state_dbg;

    toe_conn_ctrl_if #(.ID_W(ID_W), .MAC_W(MAC_W)) bus ();

    toe_conn_ctrl #(.DEPTH(DEPTH), .ID_W(ID_W), .MAC_W(MAC_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       code;
        logic [31:0]      ip_src;
        logic [31:0]      ip_dst;
        logic [MAC_W-1:0] mac_src;
        logic [MAC_W-1:0] mac_dst;
        logic [15:0]      port_src;
        logic [15:0]      port_dst;
        logic [ID_W-1:0]  id;
    } cmd_s;

    cmd_s        stage;
    cmd_s        cmd_q[$];
    logic [31:0] exp_q[$];
    logic        ovf_m;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] res_word(input logic [7:0] err, input logic tmo,
                                             input logic [1:0] code, input logic [ID_W-1:0] id);
        return (32'(id) << 16) | (32'(code) << 9) | (32'(tmo) << 8) | 32'(err);
    endfunction

    function automatic logic [31:0] stage_word(input logic [3:0] r);
        case (r)
            4'h3:    return stage.ip_src;
            4'h4:    return stage.ip_dst;
            4'h5:    return stage.mac_src[31:0];
            4'h6:    return 32'(stage.mac_src[MAC_W-1:32]);
            4'h7:    return stage.mac_dst[31:0];
            4'h8:    return 32'(stage.mac_dst[MAC_W-1:32]);
            4'h9:    return {stage.port_dst, stage.port_src};
            default: return 32'(stage.id);
        endcase
    endfunction

    task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address = a; bus.writedata = d; bus.write = 1'b1; bus.chipselect = 1'b1;
        @(negedge clk);
        bus.write = 1'b0; bus.chipselect = 1'b0;
    endtask

    task automatic csr_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.address = a; bus.read = 1'b1; bus.chipselect = 1'b1;
        @(negedge clk);
        bus.read = 1'b0; bus.chipselect = 1'b0;
        d = bus.readdata;
    endtask

    task automatic stage_set(input logic [3:0] r, input logic [31:0] v);
        case (r)
            4'h3:    stage.ip_src = v;
            4'h4:    stage.ip_dst = v;
            4'h5:    stage.mac_src[31:0] = v;
            4'h6:    stage.mac_src[MAC_W-1:32] = v[MAC_W-33:0];
            4'h7:    stage.mac_dst[31:0] = v;
            4'h8:    stage.mac_dst[MAC_W-1:32] = v[MAC_W-33:0];
            4'h9:    {stage.port_dst, stage.port_src} = v;
            default: stage.id = v[ID_W-1:0];
        endcase
        csr_write(r, v);
    endtask

    task automatic stage_random();
        logic [3:0]  r;
        logic [31:0] d;
        r = 4'($urandom_range(3, 10));
        stage_set(r, $urandom);
        csr_read(r, d);
        check($sformatf("stage_rd%0d", r), d, stage_word(r));
    endtask

    task automatic push_cmd(input logic [1:0] code);
        cmd_s c;
        c = stage;
        c.code = code;
        if (cmd_q.size() < DEPTH) cmd_q.push_back(c);
        else                      ovf_m = 1'b1;
        csr_write(4'h0, {30'd0, code});
    endtask

    task automatic serve(input int delay, input logic [ID_W-1:0] rid, input logic [7:0] err);
        int   guard;
        cmd_s c;
        guard = 0;
        while (bus.rs_rq == 2'b00 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("rq_arrive", 64'(guard < 200), 64'd1);
        if (guard < 200 && cmd_q.size() > 0) begin
            c = cmd_q[0];
            check("rs_rq", bus.rs_rq, c.code);
            check("rs_ip_src", bus.rs_ip_src, c.ip_src);
            check("rs_ip_dst", bus.rs_ip_dst, c.ip_dst);
            check("rs_mac_src", bus.rs_mac_src, c.mac_src);
            check("rs_mac_dst", bus.rs_mac_dst, c.mac_dst);
            check("rs_ports", {bus.rs_port_dst, bus.rs_port_src}, {c.port_dst, c.port_src});
            check("rs_id_out", bus.rs_id_out, c.id);
            repeat (delay) @(negedge clk);
            check("rq_stable", {bus.rs_rq, bus.rs_ip_src}, {c.code, c.ip_src});
            bus.rs_done = 1'b1; bus.rs_id_in = rid; bus.rs_error = err;
            @(negedge clk);
            bus.rs_done = 1'b0;
            void'(cmd_q.pop_front());
            exp_q.push_back(res_word(err, 1'b0, c.code, rid));
        end
    endtask

    task automatic pop_result();
        logic [31:0] d;
        csr_read(4'h2, d);
        if (exp_q.size() == 0) check("res_empty", d, 64'd0);
        else                   check("res", d, exp_q.pop_front());
        csr_write(4'h1, 32'h1);
    endtask

    task automatic check_stat(input string tag);
        logic [31:0] d;
        csr_read(4'h1, d);
        check(tag, d, {8'd0, 8'(exp_q.size()), 8'(cmd_q.size()), 5'd0, ovf_m,
                       (cmd_q.size() == DEPTH), (exp_q.size() != 0)});
    endtask

    task automatic wait_rq(input logic want_busy);
        int guard;
        guard = 0;
        while (((bus.rs_rq != 2'b00) != want_busy) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("wait_rq", 64'(guard < 200), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        int          cyc;
        logic [1:0]  code;

        bus.write = 1'b0; bus.read = 1'b0; bus.chipselect = 1'b0; bus.address = '0;
        bus.writedata = '0; bus.rs_id_in = '0; bus.rs_error = '0; bus.rs_done = 1'b0;
        stage = '0; ovf_m = 1'b0;

        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("irq_rst", bus.irq, 64'd0);
        check("rq_rst", bus.rs_rq, 64'd0);
        for (int a = 0; a < 12; a++) begin
            csr_read(4'(a), d);
            check($sformatf("reset_rd%0d", a), d, 64'd0);
        end

        // single lookup with known searcher answer
        stage_set(4'h3, 32'h0A00_0001);
        stage_set(4'h5, 32'h3344_5566);
        stage_set(4'h6, 32'h0000_1122);
        push_cmd(2'd1);
        check("rq_t1", bus.rs_rq, 64'd0);
        @(negedge clk);
        check("rq_t2", bus.rs_rq, 64'd1);
        serve(5, 8'h2A, 8'h00);
        check_stat("stat_one");
        csr_read(4'h2, d);
        check("res_direct", d, 64'h002A_0200);
        pop_result();

        // interrupt with three queued completions
        csr_write(4'hB, 32'h1);
        for (int i = 0; i < 3; i++) begin
            stage_random();
            push_cmd(2'($urandom_range(1, 3)));
            serve($urandom_range(0, 4), ID_W'($urandom), 8'($urandom));
        end
        check_stat("stat_three");
        check("irq_high", bus.irq, 64'd1);
        pop_result();
        pop_result();
        csr_read(4'h2, d);
        check("res_last", d, exp_q.pop_front());
        csr_write(4'h1, 32'h1);
        check("irq_hold", bus.irq, 64'd1);
        @(negedge clk);
        check("irq_fall", bus.irq, 64'd0);

        // overflow with a stalled searcher
        for (int i = 0; i < 6; i++) push_cmd(2'($urandom_range(1, 3)));
        check_stat("stat_ovf");
        csr_write(4'h1, 32'h4);
        ovf_m = 1'b0;
        csr_read(4'h1, d);
        check("ovf_clear", d[2], 64'd0);
`ifdef TOE_CONN_CTRL_TIMEOUT_EN
        wait_rq(1'b0);
        exp_q.push_back(res_word(8'hFF, 1'b1, cmd_q[0].code, '0));
        void'(cmd_q.pop_front());
`endif
        while (cmd_q.size() > 0) serve($urandom_range(0, 3), ID_W'($urandom), 8'($urandom));
        check_stat("stat_drain");
        while (exp_q.size() > 0) pop_result();

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() > 0 && (exp_q.size() == DEPTH || $urandom_range(0, 1) == 1))
                pop_result();
            if ($urandom_range(0, 1) == 1) stage_random();
            if ($urandom_range(0, 5) == 0) csr_write(4'h0, 32'h0);
            if ($urandom_range(0, 7) == 0) begin
                csr_write(4'($urandom_range(12, 15)), $urandom);
                csr_read(4'($urandom_range(12, 15)), d);
                check("unmapped", d, 64'd0);
            end
            push_cmd(2'($urandom_range(1, 3)));
            serve($urandom_range(0, 6), ID_W'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) check_stat("stat_rand");
        end
        while (exp_q.size() > 0) pop_result();
        check_stat("stat_rand_end");

        // searcher never answers
        push_cmd(2'd2);
`ifdef TOE_CONN_CTRL_TIMEOUT_EN
        wait_rq(1'b1);
        cyc = 0;
        while (bus.rs_rq != 2'b00 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("tmo_cycles", 64'(cyc), 64'(TIMEOUT));
        exp_q.push_back(res_word(8'hFF, 1'b1, 2'd2, '0));
        void'(cmd_q.pop_front());
        pop_result();
`else
        repeat (1000) @(negedge clk);
        cyc = 1000;
        check("still_busy_rq", bus.rs_rq, 64'd2);
        csr_read(4'h0, d);
        check("still_busy_cmd", d, 64'h0000_0102);
        serve(0, ID_W'($urandom), 8'($urandom));
        pop_result();
`endif

        // reset during WAIT
        code = 2'd3;
        push_cmd(code);
        wait_rq(1'b1);
        #2 rst = 1'b1;
        #1 check("rq_async_rst", bus.rs_rq, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cmd_q.delete();
        exp_q.delete();
        ovf_m = 1'b0;
        stage = '0;
        check("irq_after_rst", bus.irq, 64'd0);
        check_stat("stat_after_rst");
        stage_random();
        push_cmd(2'd1);
        serve(2, ID_W'($urandom), 8'($urandom));
        check_stat("stat_post_rst");
        pop_result();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
